// File: rtl/id_stage_ctrl.sv
// Registered instruction-decode stage for the RV32IM core.
//
// Decodes the incoming instruction combinationally into the datapath control
// bundle. The bundle is held in an output pipeline register with a
// valid/ready handshake. Load-use hazards against the load held in EX stall
// the input side. A flush kills the held bundle and any incoming instruction.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid_i/in_ready_o handshake from the IF buffer
//   in_inst_i, in_pc_i    instruction word and its PC
//   flush_i               kill held and incoming instruction
//   ex_load_valid_i/rd_i  load currently in EX, used for hazard detection
//   out_valid_o/ready_i   handshake towards EX
//   out_pc_o ... illegal_o registered decoded control bundle
module id_stage_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter bit          ENABLE_M     = 1'b1,
  parameter bit          ILLEGAL_PASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_inst_i,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic            flush_i,
  input  logic            ex_load_valid_i,
  input  logic [4:0]      ex_load_rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output logic            mem_rd_o,
  output logic            mem_wr_o,
  output logic            reg_wr_o,
  output logic [2:0]      rw_type_o,
  output logic [1:0]      wb_sel_o,
  output logic            alu_src1_o,
  output logic            alu_src2_o,
  output logic [4:0]      alu_ctl_o,
  output logic [2:0]      br_type_o,
  output logic            jump_o,
  output logic            illegal_o
);

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [4:0] AluAdd  = 5'd0;
  localparam logic [4:0] AluSub  = 5'd1;
  localparam logic [4:0] AluMul  = 5'd2;
  localparam logic [4:0] AluAnd  = 5'd10;
  localparam logic [4:0] AluOr   = 5'd11;
  localparam logic [4:0] AluXor  = 5'd12;
  localparam logic [4:0] AluSll  = 5'd14;
  localparam logic [4:0] AluSrl  = 5'd15;
  localparam logic [4:0] AluSra  = 5'd16;
  localparam logic [4:0] AluSltu = 5'd17;
  localparam logic [4:0] AluSlt  = 5'd18;

  localparam logic [1:0] WbPc4 = 2'd0;
  localparam logic [1:0] WbAlu = 2'd1;
  localparam logic [1:0] WbImm = 2'd2;
  localparam logic [1:0] WbMem = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
    logic [2:0]      rw_type;
    logic [1:0]      wb_sel;
    logic            alu_src1;
    logic            alu_src2;
    logic [4:0]      alu_ctl;
    logic [2:0]      br_type;
    logic            jump;
    logic            illegal;
  } bundle_t;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_r, is_imm, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
  logic       is_itype, uses_rs1, uses_rs2, stall, load_ready, accept;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0] base_alu, alu;
  logic [2:0] br;
  logic       ill;
  bundle_t    dec, bundle_d, bundle_q;
  logic       valid_d, valid_q;

  assign opcode = in_inst_i[6:0];
  assign funct3 = in_inst_i[14:12];
  assign funct7 = in_inst_i[31:25];

  assign is_r      = (opcode == OpcR);
  assign is_imm    = (opcode == OpcImm);
  assign is_load   = (opcode == OpcLoad);
  assign is_store  = (opcode == OpcStore);
  assign is_branch = (opcode == OpcBranch);
  assign is_lui    = (opcode == OpcLui);
  assign is_auipc  = (opcode == OpcAuipc);
  assign is_jal    = (opcode == OpcJal);
  assign is_jalr   = (opcode == OpcJalr);
  assign is_itype  = is_imm | is_load | is_jalr;

  assign imm_i = {{(XLEN-12){in_inst_i[31]}}, in_inst_i[31:20]};
  assign imm_s = {{(XLEN-12){in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
  assign imm_b = {{(XLEN-13){in_inst_i[31]}}, in_inst_i[31], in_inst_i[7], in_inst_i[30:25],
                  in_inst_i[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){in_inst_i[31]}}, in_inst_i[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){in_inst_i[31]}}, in_inst_i[31], in_inst_i[19:12], in_inst_i[20],
                  in_inst_i[30:21], 1'b0};

  // funct3 -> ALU op shared by R-type and I-type arithmetic.
  always_comb begin
    base_alu = AluAdd;
    case (funct3)
      3'd1:    base_alu = AluSll;
      3'd2:    base_alu = AluSlt;
      3'd3:    base_alu = AluSltu;
      3'd4:    base_alu = AluXor;
      3'd5:    base_alu = AluSrl;
      3'd6:    base_alu = AluOr;
      3'd7:    base_alu = AluAnd;
      default: base_alu = AluAdd;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc_i;
    dec.rs1     = in_inst_i[19:15];
    dec.rs2     = in_inst_i[24:20];
    dec.rd      = in_inst_i[11:7];
    dec.wb_sel  = WbAlu;
    alu         = AluAdd;
    br          = 3'd0;
    ill         = 1'b0;
    case (opcode)
      OpcR: begin
        case (funct7)
          7'h00: alu = base_alu;
          7'h20: begin
            if (funct3 == 3'd0)      alu = AluSub;
            else if (funct3 == 3'd5) alu = AluSra;
            else                     ill = 1'b1;
          end
          7'h01: begin
            if (ENABLE_M) alu = AluMul + {2'b00, funct3};
            else          ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OpcImm: begin
        dec.imm = imm_i;
        alu     = base_alu;
        if (funct3 == 3'd1 && funct7 != 7'h00) ill = 1'b1;
        if (funct3 == 3'd5) begin
          if (funct7 == 7'h20)      alu = AluSra;
          else if (funct7 != 7'h00) ill = 1'b1;
        end
      end
      OpcLoad: begin
        dec.imm     = imm_i;
        dec.rw_type = funct3;
        dec.wb_sel  = WbMem;
        ill         = (funct3 == 3'd3) | (funct3 == 3'd6) | (funct3 == 3'd7);
      end
      OpcStore: begin
        dec.imm     = imm_s;
        dec.rw_type = funct3;
        ill         = (funct3 > 3'd2);
      end
      OpcBranch: begin
        dec.imm = imm_b;
        case (funct3)
          3'd0:    br = 3'd1;
          3'd1:    br = 3'd2;
          3'd4:    br = 3'd3;
          3'd5:    br = 3'd4;
          3'd6:    br = 3'd5;
          3'd7:    br = 3'd6;
          default: ill = 1'b1;
        endcase
      end
      OpcLui: begin
        dec.imm    = imm_u;
        dec.wb_sel = WbImm;
      end
      OpcAuipc: dec.imm = imm_u;
      OpcJal: begin
        dec.imm    = imm_j;
        dec.wb_sel = WbPc4;
      end
      OpcJalr: begin
        dec.imm    = imm_i;
        dec.wb_sel = WbPc4;
        ill        = (funct3 != 3'd0);
      end
      default: ill = 1'b1;
    endcase

    dec.alu_src1 = is_branch | is_auipc | is_jal;
    dec.alu_src2 = is_itype | is_store | is_auipc | is_jal | is_branch;
    // Illegal encodings must not produce side effects downstream.
    dec.reg_wr   = ~ill & (is_r | is_itype | is_lui | is_auipc | is_jal);
    dec.mem_rd   = ~ill & is_load;
    dec.mem_wr   = ~ill & is_store;
    dec.jump     = ~ill & (is_jal | is_jalr);
    dec.br_type  = ill ? 3'd0 : br;
    dec.alu_ctl  = ill ? AluAdd : alu;
    dec.illegal  = ill;
  end

  assign uses_rs1 = is_r | is_imm | is_load | is_jalr | is_store | is_branch;
  assign uses_rs2 = is_r | is_store | is_branch;
  assign stall    = ex_load_valid_i & (ex_load_rd_i != 5'd0) &
                    ((uses_rs1 & (dec.rs1 == ex_load_rd_i)) |
                     (uses_rs2 & (dec.rs2 == ex_load_rd_i)));

  assign load_ready = ~valid_q | out_ready_i;
  assign in_ready_o = load_ready & ~stall;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      bundle_d = dec;
      valid_d  = ILLEGAL_PASS | ~dec.illegal;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_pc_o    = bundle_q.pc;
  assign rs1_o       = bundle_q.rs1;
  assign rs2_o       = bundle_q.rs2;
  assign rd_o        = bundle_q.rd;
  assign imm_o       = bundle_q.imm;
  assign mem_rd_o    = bundle_q.mem_rd;
  assign mem_wr_o    = bundle_q.mem_wr;
  assign reg_wr_o    = bundle_q.reg_wr;
  assign rw_type_o   = bundle_q.rw_type;
  assign wb_sel_o    = bundle_q.wb_sel;
  assign alu_src1_o  = bundle_q.alu_src1;
  assign alu_src2_o  = bundle_q.alu_src2;
  assign alu_ctl_o   = bundle_q.alu_ctl;
  assign br_type_o   = bundle_q.br_type;
  assign jump_o      = bundle_q.jump;
  assign illegal_o   = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl. Two instances share the stimulus: dut0 with the
// M extension and illegal pass-through, dut1 without M and dropping illegal
// instructions. A decode/handshake model checks both every cycle; directed
// literal checks pin the model against hand-decoded instructions.
module tb_id_stage_ctrl;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic [2:0]  rw_type;
    logic [1:0]  wb_sel;
    logic        alu_src1;
    logic        alu_src2;
    logic [4:0]  alu_ctl;
    logic [2:0]  br_type;
    logic        jump;
    logic        illegal;
  } bundle_t;

  logic        clk, rst_n;
  logic        in_valid, flush, ex_load_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [4:0]  ex_load_rd;

  logic        a_in_ready, a_out_valid, a_mem_rd, a_mem_wr, a_reg_wr, a_src1, a_src2;
  logic        a_jump, a_illegal;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_alu;
  logic [2:0]  a_rw, a_br;
  logic [1:0]  a_wb;
  logic        b_in_ready, b_out_valid, b_mem_rd, b_mem_wr, b_reg_wr, b_src1, b_src2;
  logic        b_jump, b_illegal;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_alu;
  logic [2:0]  b_rw, b_br;
  logic [1:0]  b_wb;

  bundle_t act_a, act_b;
  assign act_a = {a_rs1, a_rs2, a_rd, a_imm, a_mem_rd, a_mem_wr, a_reg_wr, a_rw, a_wb,
                  a_src1, a_src2, a_alu, a_br, a_jump, a_illegal};
  assign act_b = {b_rs1, b_rs2, b_rd, b_imm, b_mem_rd, b_mem_wr, b_reg_wr, b_rw, b_wb,
                  b_src1, b_src2, b_alu, b_br, b_jump, b_illegal};

  id_stage_ctrl #(.XLEN(32), .ENABLE_M(1'b1), .ILLEGAL_PASS(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_inst_i(in_inst), .in_pc_i(in_pc), .flush_i(flush), .ex_load_valid_i(ex_load_valid),
    .ex_load_rd_i(ex_load_rd), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .out_pc_o(a_pc), .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd), .imm_o(a_imm),
    .mem_rd_o(a_mem_rd), .mem_wr_o(a_mem_wr), .reg_wr_o(a_reg_wr), .rw_type_o(a_rw),
    .wb_sel_o(a_wb), .alu_src1_o(a_src1), .alu_src2_o(a_src2), .alu_ctl_o(a_alu),
    .br_type_o(a_br), .jump_o(a_jump), .illegal_o(a_illegal)
  );

  id_stage_ctrl #(.XLEN(32), .ENABLE_M(1'b0), .ILLEGAL_PASS(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_inst_i(in_inst), .in_pc_i(in_pc), .flush_i(flush), .ex_load_valid_i(ex_load_valid),
    .ex_load_rd_i(ex_load_rd), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .out_pc_o(b_pc), .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd), .imm_o(b_imm),
    .mem_rd_o(b_mem_rd), .mem_wr_o(b_mem_wr), .reg_wr_o(b_reg_wr), .rw_type_o(b_rw),
    .wb_sel_o(b_wb), .alu_src1_o(b_src1), .alu_src2_o(b_src2), .alu_ctl_o(b_alu),
    .br_type_o(b_br), .jump_o(b_jump), .illegal_o(b_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [4:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'd0: return 5'd0;   // add
      3'd1: return 5'd14;  // sll
      3'd2: return 5'd18;  // slt
      3'd3: return 5'd17;  // sltu
      3'd4: return 5'd12;  // xor
      3'd5: return 5'd15;  // srl
      3'd6: return 5'd11;  // or
      default: return 5'd10; // and
    endcase
  endfunction

  function automatic logic [2:0] br_of(input logic [2:0] f3);
    case (f3)
      3'd0: return 3'd1;
      3'd1: return 3'd2;
      3'd4: return 3'd3;
      3'd5: return 3'd4;
      3'd6: return 3'd5;
      3'd7: return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bundle_t mdecode(input logic [31:0] inst, input bit en_m);
    bundle_t b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit bad;
    logic [4:0] alu;
    logic [2:0] br;
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    b = '0; bad = 0; alu = 5'd0; br = 3'd0;
    b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.rd = inst[11:7];
    b.wb_sel = 2'd1;
    case (op)
      7'h33: begin
        if (f7 == 7'h00)                    alu = f3_alu(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 5'd16;
        else if (f7 == 7'h01 && en_m)       alu = 5'(2 + f3);
        else                                bad = 1;
      end
      7'h13: begin
        b.imm = 32'($signed(inst[31:20]));
        alu = f3_alu(f3);
        if (f3 == 3'd1 && f7 != 7'h00) bad = 1;
        if (f3 == 3'd5 && f7 == 7'h20) alu = 5'd16;
        else if (f3 == 3'd5 && f7 != 7'h00) bad = 1;
      end
      7'h03: begin
        b.imm = 32'($signed(inst[31:20])); b.rw_type = f3; b.wb_sel = 2'd3;
        bad = (f3 inside {3'd3, 3'd6, 3'd7});
      end
      7'h23: begin
        b.imm = 32'($signed({inst[31:25], inst[11:7]})); b.rw_type = f3;
        bad = (f3 > 3'd2);
      end
      7'h63: begin
        b.imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        br = br_of(f3);
        bad = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h37: begin b.imm = {inst[31:12], 12'h000}; b.wb_sel = 2'd2; end
      7'h17: b.imm = {inst[31:12], 12'h000};
      7'h6F: begin
        b.imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        b.wb_sel = 2'd0;
      end
      7'h67: begin
        b.imm = 32'($signed(inst[31:20])); b.wb_sel = 2'd0; bad = (f3 != 3'd0);
      end
      default: bad = 1;
    endcase
    b.alu_src1 = op inside {7'h63, 7'h17, 7'h6F};
    b.alu_src2 = op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h17, 7'h6F, 7'h63};
    b.reg_wr   = !bad && (op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h6F});
    b.mem_rd   = !bad && op == 7'h03;
    b.mem_wr   = !bad && op == 7'h23;
    b.jump     = !bad && (op inside {7'h6F, 7'h67});
    b.br_type  = bad ? 3'd0 : br;
    b.alu_ctl  = bad ? 5'd0 : alu;
    b.illegal  = bad;
    return b;
  endfunction

  function automatic bit mstall(input logic [31:0] inst, input logic lv, input logic [4:0] lrd);
    bit u1, u2;
    u1 = inst[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63};
    u2 = inst[6:0] inside {7'h33, 7'h23, 7'h63};
    return lv && lrd != 5'd0 &&
           ((u1 && inst[19:15] == lrd) || (u2 && inst[24:20] == lrd));
  endfunction

  logic    exp_v  [2];
  bundle_t exp_b  [2];
  logic [31:0] exp_pc [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        exp_v[i]  <= 1'b0;
        exp_b[i]  <= '0;
        exp_pc[i] <= '0;
      end else begin
        bundle_t d;
        bit rdy;
        d   = mdecode(in_inst, i == 0);
        rdy = (!exp_v[i] || out_ready) && !mstall(in_inst, ex_load_valid, ex_load_rd);
        if (flush) begin
          exp_v[i] <= 1'b0;
        end else if (in_valid && rdy) begin
          exp_b[i]  <= d;
          exp_pc[i] <= in_pc;
          exp_v[i]  <= (i == 0) || !d.illegal;
        end else if (out_ready) begin
          exp_v[i] <= 1'b0;
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input logic rdy, input logic v, input logic [31:0] pc,
                          input bundle_t act);
    logic er;
    er = (!exp_v[i] || out_ready) && !mstall(in_inst, ex_load_valid, ex_load_rd);
    check($sformatf("dut%0d.in_ready", i), rdy, er);
    check($sformatf("dut%0d.out_valid", i), v, exp_v[i]);
    check($sformatf("dut%0d.out_pc", i), pc, exp_pc[i]);
    check($sformatf("dut%0d.bundle", i), act, exp_b[i]);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, a_in_ready, a_out_valid, a_pc, act_a);
    cmp_inst(1, b_in_ready, b_out_valid, b_pc, act_b);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl [18];

  initial begin
    tbl = '{32'h0020A423, 32'h123452B7, 32'h00001317, 32'h008000EF, 32'h000280E7,
            32'h00309093, 32'h02309093, 32'h4030D093, 32'h402081B3, 32'h4020D1B3,
            32'h0020B1B3, 32'h0020E863, 32'hFFF0C203, 32'h0000B103, 32'h0020B423,
            32'h0000000F, 32'h000290E7, 32'h0220C1B3};
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0; flush = 1'b0;
    ex_load_valid = 1'b0; ex_load_rd = 5'd0; out_ready = 1'b1;
    tick(); tick();
    check("reset.out_valid", a_out_valid, 1'b0);
    check("reset.imm", a_imm, 32'h0);
    check("reset.reg_wr", a_reg_wr, 1'b0);
    rst_n = 1'b1;

    // addi x1,x0,5
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h100;
    tick();
    check("basic.out_valid", a_out_valid, 1'b1);
    check("basic.rd", a_rd, 5'd1);
    check("basic.imm", a_imm, 32'd5);
    check("basic.alu_ctl", a_alu, 5'd0);
    check("basic.alu_src2", a_src2, 1'b1);
    check("basic.wb_sel", a_wb, 2'd1);
    check("basic.reg_wr", a_reg_wr, 1'b1);
    check("basic.out_pc", a_pc, 32'h100);

    // lw x2,0(x1) then add x3,x2,x1 under a load-use hazard
    in_inst = 32'h0000A103; in_pc = 32'h104;
    tick();
    check("lw.mem_rd", a_mem_rd, 1'b1);
    check("lw.wb_sel", a_wb, 2'd3);
    ex_load_valid = 1'b1; ex_load_rd = 5'd2; in_inst = 32'h001101B3; in_pc = 32'h108;
    #1;
    check("stall.in_ready", a_in_ready, 1'b0);
    tick();
    check("stall.out_valid", a_out_valid, 1'b0);
    ex_load_valid = 1'b0;
    tick();
    check("add.out_valid", a_out_valid, 1'b1);
    check("add.alu_ctl", a_alu, 5'd0);
    check("add.rs1", a_rs1, 5'd2);
    check("add.rs2", a_rs2, 5'd1);

    // beq x0,x0,-4
    in_inst = 32'hFE000EE3;
    tick();
    check("beq.imm", a_imm, 32'hFFFFFFFC);
    check("beq.br_type", a_br, 3'd1);
    check("beq.alu_src1", a_src1, 1'b1);
    check("beq.reg_wr", a_reg_wr, 1'b0);

    // mul x1,x2,x3 with and without M
    in_inst = 32'h023100B3;
    tick();
    check("mul.alu_ctl", a_alu, 5'd2);
    check("mul.illegal", a_illegal, 1'b0);
    check("nom.illegal", b_illegal, 1'b1);
    check("nom.reg_wr", b_reg_wr, 1'b0);
    check("nom.out_valid", b_out_valid, 1'b0);

    // backpressure then flush with a competing valid input
    in_inst = 32'h00500093;
    tick();
    out_ready = 1'b0; in_inst = 32'h00A00113;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold.out_valid", a_out_valid, 1'b1);
      check("hold.rd", a_rd, 5'd1);
      check("hold.imm", a_imm, 32'd5);
      check("hold.in_ready", a_in_ready, 1'b0);
    end
    flush = 1'b1; out_ready = 1'b1;
    tick();
    check("flush.out_valid", a_out_valid, 1'b0);
    check("flush.rd", a_rd, 5'd1);
    flush = 1'b0;

    // asynchronous reset while holding a valid bundle
    in_inst = 32'h00500093;
    tick();
    check("pre_rst.out_valid", a_out_valid, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.out_valid", a_out_valid, 1'b0);
    check("async_rst.rd", a_rd, 5'd0);
    tick();
    rst_n = 1'b1;

    // mixed instructions, readiness, hazards and a flush; checked by the model
    for (int k = 0; k < 18; k++) begin
      in_inst       = tbl[k];
      in_pc         = 32'h2000 + 32'(4 * k);
      in_valid      = (k % 5 != 4);
      out_ready     = (k % 3 != 2);
      ex_load_valid = (k % 4 == 1) || (k % 4 == 3);
      ex_load_rd    = (k % 4 == 1) ? 5'd1 : 5'd0;
      flush         = (k == 7);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; ex_load_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
